// File: rtl/ahb_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module  : ahb_arbiter_mux
// Brief   : Two-master round-robin AHB arbiter with address/control/write-data
//           muxes, SPLIT masking and per-tenure beat limit. Optional HLOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_arbiter_mux #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hbusreq_m1,
    input  logic              hbusreq_m2,
    input  logic [ADDR_W-1:0] haddr_m1,
    input  logic [ADDR_W-1:0] haddr_m2,
    input  logic              hwrite_m1,
    input  logic              hwrite_m2,
    input  logic [DATA_W-1:0] hwdata_m1,
    input  logic [DATA_W-1:0] hwdata_m2,
`ifdef HLOCK_EN
    input  logic              hlock_m1,
    input  logic              hlock_m2,
`endif
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [15:0]       hsplit,
    output logic              hgrant_m1,
    output logic              hgrant_m2,
    output logic [3:0]        hmaster,
    output logic [3:0]        hmaster_data,
    output logic [ADDR_W-1:0] haddr_mux_out,
    output logic              hwrite_mux_out,
    output logic [DATA_W-1:0] hwdata_mux_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2
    } state_t;

    localparam logic [7:0] BEAT_LAST = 8'(MAX_BEATS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] beat_cnt;
    logic       ptr_m2;
    logic [1:0] split_mask;     // bit 0 = master 1, bit 1 = master 2
    logic [1:0] split_set;
    logic       pending;
    logic       elig_m1;
    logic       elig_m2;
    logic       owner_lock;
    logic       limit_ok;
    logic       unused_hsplit;

    assign unused_hsplit = ^{hsplit[15:3], hsplit[0]};

    assign elig_m1 = hbusreq_m1 & ~split_mask[0];
    assign elig_m2 = hbusreq_m2 & ~split_mask[1];

`ifdef HLOCK_EN
    assign owner_lock = ((state == OWN_M1) & hlock_m1) | ((state == OWN_M2) & hlock_m2);
`else
    assign owner_lock = 1'b0;
`endif

    assign limit_ok = (beat_cnt < BEAT_LAST) | owner_lock;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
        end else if (hready) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (elig_m1 && elig_m2) state_nxt = ptr_m2 ? OWN_M2 : OWN_M1;
                else if (elig_m1)       state_nxt = OWN_M1;
                else if (elig_m2)       state_nxt = OWN_M2;
                else                    state_nxt = IDLE;
            end
            OWN_M1: begin
                if (elig_m1 && !pending && (!elig_m2 || limit_ok)) state_nxt = OWN_M1;
                else if (elig_m2)                                  state_nxt = OWN_M2;
                else if (elig_m1)                                  state_nxt = OWN_M1;
                else                                               state_nxt = IDLE;
            end
            OWN_M2: begin
                if (elig_m2 && !pending && (!elig_m1 || limit_ok)) state_nxt = OWN_M2;
                else if (elig_m1)                                  state_nxt = OWN_M1;
                else if (elig_m2)                                  state_nxt = OWN_M2;
                else                                               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SPLIT response masks whichever master is in its data phase
    always_comb begin
        split_set = 2'b00;
        if (!hready && (hresp == 2'b11)) begin
            split_set[0] = (hmaster_data == 4'd1);
            split_set[1] = (hmaster_data == 4'd2);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hmaster_data <= 4'd0;
            beat_cnt     <= 8'd0;
            ptr_m2       <= 1'b0;
            pending      <= 1'b0;
            split_mask   <= 2'b00;
        end else begin
            split_mask <= (split_mask & ~hsplit[2:1]) | split_set;
            if (hready) begin
                hmaster_data <= hmaster;
                pending      <= 1'b0;
                if ((state_nxt != state) || (state_nxt == IDLE)) begin
                    beat_cnt <= 8'd0;
                end else if (beat_cnt < BEAT_LAST) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if ((state_nxt != state) && (state_nxt == OWN_M1)) ptr_m2 <= 1'b1;
                if ((state_nxt != state) && (state_nxt == OWN_M2)) ptr_m2 <= 1'b0;
            end else if (hresp[1]) begin
                pending <= 1'b1;
            end
        end
    end

    assign hgrant_m1 = (state == OWN_M1);
    assign hgrant_m2 = (state == OWN_M2);

    always_comb begin
        case (state)
            OWN_M1:  hmaster = 4'd1;
            OWN_M2:  hmaster = 4'd2;
            default: hmaster = 4'd0;
        endcase
    end

    always_comb begin
        case (hmaster)
            4'd1: begin
                haddr_mux_out  = haddr_m1;
                hwrite_mux_out = hwrite_m1;
            end
            4'd2: begin
                haddr_mux_out  = haddr_m2;
                hwrite_mux_out = hwrite_m2;
            end
            default: begin
                haddr_mux_out  = '0;
                hwrite_mux_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (hmaster_data)
            4'd1:    hwdata_mux_out = hwdata_m1;
            4'd2:    hwdata_mux_out = hwdata_m2;
            default: hwdata_mux_out = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter_mux.md
Name: ahb_arbiter_mux

Overview:
Two-master AHB arbiter with integrated address, control and write-data multiplexers. It sits directly upstream of the slave top and generates haddr_mux_out, hwrite_mux_out and hwdata_mux_out. It consumes the slave's hready, hresp and hsplit outputs to pipeline ownership, mask SPLIT masters and unmask them again. Arbitration is round-robin with a beat limit per tenure.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, write-data width
MAX_BEATS, 16, hready-high beats a master may hold the bus while the other master is waiting (range 1..255)

Ports:
hclk  in  1  master clock
hresetn  in  1  asynchronous active-low reset
hbusreq_m1  in  1  bus request, master 1 (ID 1)
hbusreq_m2  in  1  bus request, master 2 (ID 2)
haddr_m1  in  ADDR_W  address, master 1
haddr_m2  in  ADDR_W  address, master 2
hwrite_m1  in  1  write strobe, master 1
hwrite_m2  in  1  write strobe, master 2
hwdata_m1  in  DATA_W  write data, master 1
hwdata_m2  in  DATA_W  write data, master 2
hready  in  1  transfer done, from slave
hresp  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
hsplit  in  16  per-ID unsplit request, from slave
hgrant_m1  out  1  grant, master 1
hgrant_m2  out  1  grant, master 2
hmaster  out  4  address-phase owner ID (0 = none)
hmaster_data  out  4  data-phase owner ID
haddr_mux_out  out  ADDR_W  muxed address
hwrite_mux_out  out  1  muxed write strobe
hwdata_mux_out  out  DATA_W  muxed write data

Behaviour:
- Reset values: state IDLE; hgrant_m1 = hgrant_m2 = 0; hmaster = 0; hmaster_data = 0; split_mask = 0; beat_cnt = 0; priority pointer = M1. Reset may assert mid-burst; it clears all state immediately.
- Eligibility: a master is eligible when its hbusreq is 1 and its split_mask bit is 0.
- FSM states: IDLE, OWN_M1, OWN_M2.
- Registered outputs: hgrant_m1 = (state == OWN_M1); hgrant_m2 = (state == OWN_M2); hmaster = 1, 2 or 0 to match the state.
- State updates only on an edge where hready = 1. Otherwise all state, beat_cnt and the pointer hold.
- Next owner, evaluated on an hready-high edge:
  - The current owner keeps the bus if it is eligible, no RETRY or SPLIT is pending, and either the other master is not eligible or beat_cnt < MAX_BEATS-1.
  - Otherwise the bus goes to the other master if it is eligible.
  - If neither applies, the current owner keeps it if eligible; else the state goes to IDLE.
  - From IDLE: the single eligible master wins. If both are eligible, the master at the pointer wins.
- Pointer: on every ownership change to master X, the pointer moves to the other master.
- beat_cnt: cleared on an ownership change or in IDLE. It increments on each hready-high edge while the owner holds, saturating at MAX_BEATS-1.
- Data-phase pipeline: on an hready-high edge, hmaster_data <= hmaster. With hready = 0, hmaster_data holds.
- Muxes (combinational):
  - haddr_mux_out and hwrite_mux_out select by hmaster.
  - hwdata_mux_out selects by hmaster_data.
  - ID 0 drives all-zero address/data and hwrite_mux_out = 0.
  - Latency: grant appears 1 cycle after the request; address follows the grant the same cycle; data follows 1 hready-high cycle later.
- SPLIT:
  - hresp = 11 with hready = 0 sets split_mask[hmaster_data] and raises a pending flag.
  - On the next hready-high edge, the owner (if it is that master) loses the bus even mid-burst.
- RETRY: hresp = 10 with hready = 0 raises the pending flag only. The owner loses the bus to the other master if that master is eligible; otherwise the owner is re-granted.
- ERROR: no arbitration effect.
- Unmask: hsplit[1] clears split_mask[1] and hsplit[2] clears split_mask[2] in any cycle. hsplit bits 0 and 3..15 are ignored.
- Simultaneous set and clear of the same mask bit: set wins.
- Both masters masked, or no requests: IDLE, no grants, bus driven to zero.

Optional Feature:
HLOCK_EN
- Defined: adds input ports hlock_m1 and hlock_m2 (1 bit each).
  - While the owner's hlock is 1, the beat limit is ignored and the owner keeps the bus.
  - SPLIT and RETRY still force loss of ownership.
  - hlock of a non-owner has no effect.
- Undefined: the ports are absent and the beat limit always applies.

Test Plan:
1. Reset, then hbusreq_m1 = 1, hready = 1 → next edge: hgrant_m1 = 1, hmaster = 1, haddr_mux_out = haddr_m1 (0x0000_1000). One edge later: hmaster_data = 1, hwdata_mux_out = hwdata_m1.
2. Both masters request from IDLE after reset → M1 granted. With MAX_BEATS = 4 and continuous hready, M1 holds for 4 edges, then hgrant_m2 = 1, hmaster = 2. After M2's 4 beats, M1 is granted again.
3. M1 owns; hready = 0 for 3 cycles → hmaster, hmaster_data and hwdata_mux_out stay unchanged and beat_cnt holds.
4. M1 in data phase, slave returns hresp = 11 / hready = 0, then 11 / hready = 1 → split_mask[1] = 1 and the bus goes to M2 (or IDLE if M2 is not requesting). Later hsplit = 16'h0002 → mask cleared and M1 becomes eligible again.
5. hresp = 10 (RETRY) with only M1 requesting → M1 is re-granted; split_mask stays 0.
6. Assert hresetn = 0 mid-burst while M2 owns → grants, hmaster, hmaster_data and split_mask are 0 immediately, and haddr_mux_out = 0.
